y_out_buffer: RTL
=================

Y_OUT_BUFFER -- requirements
Module: y_out_buffer

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entry count; power of two, 2..16.
REQ-002 Parameter: CNTW, 8, width of the drop counter.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: y_in  input  13  result word from the arithmetic pipeline, sign-magnitude: bit 12 = sign, bits 11:0 = Q0.12 magnitude.
REQ-006 Port: y_valid  input  1  y_in is valid this cycle; there is no back-pressure toward the producer.
REQ-007 Port: out_data  output  14  two's-complement result, Q1.12 (bit 13 = sign).
REQ-008 Port: out_valid  output  1  out_data holds the oldest buffered entry.
REQ-009 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 Port: level  output  log2(DEPTH)+1  number of buffered entries.
REQ-011 Port: overflow  output  1  sticky flag: at least one sample has been dropped since reset.
REQ-012 Port: drop_cnt  output  CNTW  count of dropped samples, saturating.

Function
REQ-013 Conversion: the entry written for y_in SHALL be {1'b0, mag} when sign=0, and 0 - {1'b0, mag} in 14-bit two's complement when sign=1.
REQ-014 Negative zero: when sign=1 and mag=0, the written entry SHALL be 14'h0000.
REQ-015 Conversion SHALL happen before storage; the FIFO stores 14-bit converted words.
REQ-016 Push: push SHALL occur when y_valid=1 and either level<DEPTH or a pop occurs in the same cycle.
REQ-017 Pop: pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 Ordering: entries SHALL leave in strict arrival order.
REQ-019 Latency: a sample pushed at edge N SHALL be visible on out_data/out_valid after edge N, with no combinational path from y_in to out_data.
REQ-020 Empty FIFO: when level=0, out_valid SHALL be 0 and out_data SHALL hold its last value (0 after reset).
REQ-021 Output stability: out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop when full: both SHALL be accepted, and level SHALL remain DEPTH.
REQ-023 Simultaneous push and pop at level=1: the new entry SHALL become the head at the next edge, and out_valid SHALL stay 1.
REQ-024 Drop: a drop SHALL occur when y_valid=1, level=DEPTH and no pop occurs in that cycle.
REQ-025 On a drop, the sample SHALL be discarded, the contents SHALL be unchanged, overflow SHALL be set to 1, and drop_cnt SHALL increment.
REQ-026 drop_cnt SHALL saturate at 2^CNTW-1 and never wrap.
REQ-027 level SHALL equal the entry count after each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 out_ready asserted while level=0 SHALL be ignored, with no state change.

Reset
REQ-030 While rst=1 at an edge, out_valid, level, overflow, drop_cnt and out_data SHALL all become 0, and the read and write pointers SHALL become 0.
REQ-031 Reset SHALL take priority over a simultaneous push or pop; all buffered entries SHALL be discarded.
REQ-032 The first sample after reset SHALL be accepted on the cycle following deassertion of rst.

Verification
REQ-033 Single sample: push y_in=13'h0800 (+0.5) with out_ready=1 -> one cycle later out_data=14'h0800 and out_valid=1, then level returns to 0.
REQ-034 Negative conversion: push 13'h1800, then 13'h1FFF, then 13'h1000 -> out_data sequence 14'h3800, 14'h3001, 14'h0000.
REQ-035 Fill and drop: out_ready=0, push 6 samples with DEPTH=4 -> level=4, overflow=1, drop_cnt=2, and the first 4 samples drain in order once out_ready=1.
REQ-036 Full push and pop: at level=4, y_valid=1 and out_ready=1 for 10 cycles -> no drops, level stays 4, and the output stream equals the input stream delayed by 4 entries.
REQ-037 Saturation: CNTW=2, 5 drops -> drop_cnt=3.
REQ-038 Reset mid-operation: level=3, assert rst for one cycle alongside y_valid=1 -> level=0, out_valid=0, overflow=0 and drop_cnt=0, with no entry surviving.

Source files
------------

// File: rtl/y_out_buffer.sv
// y_out_buffer: converts sign-magnitude results to two's complement and buffers them in a drop-on-full FIFO.
module y_out_buffer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [12:0]                y_in,
  input  logic                       y_valid,
  output logic [13:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNTW-1:0]            drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [13:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [13:0]   conv, head_nxt;
  logic          full, push, pop, drop;
  assign out_valid = cnt != '0;
  assign level     = cnt;
  always_comb begin
    conv     = y_in[12] ? 14'd0 - {2'b00, y_in[11:0]} : {2'b00, y_in[11:0]};
    full     = cnt == LW'(DEPTH);
    pop      = out_valid && out_ready;
    push     = y_valid && (!full || pop);
    drop     = y_valid && full && !pop;
    rd_nxt   = pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_nxt  = cnt + LW'(push) - LW'(pop);
    // head is registered so out_data never depends combinationally on y_in and holds when empty
    head_nxt = cnt_nxt == '0 ? out_data : (push && wr_ptr == rd_nxt) ? conv : mem[rd_nxt];
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= conv;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_nxt;
      cnt      <= cnt_nxt;
      out_data <= head_nxt;
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
    end
  end
endmodule
